// File: rtl/reflet_byte_mem_bridge.sv
// Memory-side responder for the Reflet CPU RAM bus: serves full-word CPU accesses
// from an 8-bit synchronous byte memory, with a one-word tagged read buffer.
module reflet_byte_mem_bridge #(
    parameter int wordsize = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [wordsize-1:0] cpu_addr,
    input  logic [wordsize-1:0] cpu_wdata,
    input  logic                cpu_write_en,
    output logic [wordsize-1:0] cpu_rdata,
    output logic                cpu_enable,
    output logic [wordsize-1:0] mem_addr,
    output logic [7:0]          mem_wdata,
    input  logic [7:0]          mem_rdata,
    output logic                mem_we
);

    localparam int NB = wordsize / 8;
    localparam int CW = $clog2(NB + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(NB);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        WDONE
    } state_t;

    state_t              state;
    logic [wordsize-1:0] tag;
    logic                valid;
    logic [wordsize-1:0] rbuf;
    logic [wordsize-1:0] addr_q;
    logic [wordsize-1:0] wdata_q;
    logic [CW-1:0]       cnt;

    logic                hit;
    logic [CW-1:0]       cnt_next;
    logic [CW-1:0]       cap_idx;
    logic [wordsize-1:0] addr_next;
    logic [7:0]          wbyte_next;

    assign hit       = valid && (tag == cpu_addr);
    assign cnt_next  = cnt + CW'(1);
    assign cap_idx   = cnt - CW'(1);
    // Address arithmetic wraps naturally at 2^wordsize
    assign addr_next = addr_q + {{(wordsize - CW){1'b0}}, cnt_next};
    assign cpu_rdata = rbuf;

    always_comb begin
        wbyte_next = 8'h00;
        for (int i = 0; i < NB; i++) begin
            if (cnt_next == CW'(i)) begin
                wbyte_next = wdata_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        case (state)
            IDLE:    cpu_enable = hit && !cpu_write_en;
            WDONE:   cpu_enable = 1'b1;
            default: cpu_enable = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            tag       <= '0;
            valid     <= 1'b0;
            rbuf      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            mem_we    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_write_en) begin
                        addr_q    <= cpu_addr;
                        wdata_q   <= cpu_wdata;
                        cnt       <= '0;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata[7:0];
                        mem_we    <= 1'b1;
                        state     <= WRITE;
                    end else if (!hit) begin
                        addr_q   <= cpu_addr;
                        cnt      <= '0;
                        mem_addr <= cpu_addr;
                        mem_we   <= 1'b0;
                        state    <= READ;
                    end
                end

                // Byte k is returned one cycle after its address, so capture lags by one
                READ: begin
                    if (cnt != '0) begin
                        for (int i = 0; i < NB; i++) begin
                            if (cap_idx == CW'(i)) begin
                                rbuf[8*i +: 8] <= mem_rdata;
                            end
                        end
                    end
                    if (cnt == CNT_DONE) begin
                        tag   <= addr_q;
                        valid <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_next;
                        if (cnt_next != CNT_DONE) begin
                            mem_addr <= addr_next;
                        end
                    end
                end

                WRITE: begin
                    if (cnt_next == CNT_DONE) begin
                        mem_we <= 1'b0;
                        state  <= WDONE;
                        if (valid && (tag == addr_q)) begin
                            rbuf <= wdata_q;
                        end
                    end else begin
                        cnt       <= cnt_next;
                        mem_addr  <= addr_next;
                        mem_wdata <= wbyte_next;
                    end
                end

                WDONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reflet_byte_mem_bridge.sv
// Directed bench for reflet_byte_mem_bridge with 16-, 32- and 8-bit instances,
// each backed by a synchronous byte-memory model.
module tb_reflet_byte_mem_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic        reset16, en16, we16, mwe16;
    logic [15:0] addr16, wdata16, rdata16, maddr16;
    logic [7:0]  mwd16, mrd16;
    logic [7:0]  mem16 [0:65535];

    logic        reset32, en32, we32, mwe32;
    logic [31:0] addr32, wdata32, rdata32, maddr32;
    logic [7:0]  mwd32, mrd32;
    logic [7:0]  mem32 [0:4095];

    logic        reset8, en8, we8, mwe8;
    logic [7:0]  addr8, wdata8, rdata8, maddr8;
    logic [7:0]  mwd8, mrd8;
    logic [7:0]  mem8 [0:255];

    reflet_byte_mem_bridge #(.wordsize(16)) dut16 (
        .clk(clk), .reset(reset16),
        .cpu_addr(addr16), .cpu_wdata(wdata16), .cpu_write_en(we16),
        .cpu_rdata(rdata16), .cpu_enable(en16),
        .mem_addr(maddr16), .mem_wdata(mwd16), .mem_rdata(mrd16), .mem_we(mwe16)
    );

    reflet_byte_mem_bridge #(.wordsize(32)) dut32 (
        .clk(clk), .reset(reset32),
        .cpu_addr(addr32), .cpu_wdata(wdata32), .cpu_write_en(we32),
        .cpu_rdata(rdata32), .cpu_enable(en32),
        .mem_addr(maddr32), .mem_wdata(mwd32), .mem_rdata(mrd32), .mem_we(mwe32)
    );

    reflet_byte_mem_bridge #(.wordsize(8)) dut8 (
        .clk(clk), .reset(reset8),
        .cpu_addr(addr8), .cpu_wdata(wdata8), .cpu_write_en(we8),
        .cpu_rdata(rdata8), .cpu_enable(en8),
        .mem_addr(maddr8), .mem_wdata(mwd8), .mem_rdata(mrd8), .mem_we(mwe8)
    );

    always @(posedge clk) begin
        if (mwe16) mem16[maddr16] <= mwd16;
        mrd16 <= mem16[maddr16];
        if (mwe32) mem32[maddr32[11:0]] <= mwd32;
        mrd32 <= mem32[maddr32[11:0]];
        if (mwe8) mem8[maddr8] <= mwd8;
        mrd8 <= mem8[maddr8];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset16 = 1'b0;
        addr16  = 16'h0010;
        we16    = 1'b0;
        wdata16 = 16'h0000;
        repeat (2) tick;
        total++; if (en16 !== 1'b0) $display("[TB] FAIL reset_enable: got %0h expected 0", en16); else passed++;
        total++; if (rdata16 !== 16'h0000) $display("[TB] FAIL reset_rdata: got %0h expected 0", rdata16); else passed++;
        total++; if (mwe16 !== 1'b0) $display("[TB] FAIL reset_mem_we: got %0h expected 0", mwe16); else passed++;
        total++; if (maddr16 !== 16'h0000) $display("[TB] FAIL reset_mem_addr: got %0h expected 0", maddr16); else passed++;
        reset16 = 1'b1;
    endtask

    task automatic test_miss_read;
        for (int c = 0; c < 4; c++) begin
            total++; if (en16 !== 1'b0) $display("[TB] FAIL miss_stall c%0d: got %0h expected 0", c, en16); else passed++;
            if (c == 1) begin
                total++; if (maddr16 !== 16'h0010) $display("[TB] FAIL miss_addr0: got %0h expected 10", maddr16); else passed++;
            end
            if (c == 2) begin
                total++; if (maddr16 !== 16'h0011) $display("[TB] FAIL miss_addr1: got %0h expected 11", maddr16); else passed++;
            end
            tick;
        end
        total++; if (en16 !== 1'b1) $display("[TB] FAIL miss_done_enable: got %0h expected 1", en16); else passed++;
        total++; if (rdata16 !== 16'h1234) $display("[TB] FAIL miss_rdata: got %0h expected 1234", rdata16); else passed++;
    endtask

    task automatic test_hit;
        for (int c = 0; c < 5; c++) begin
            tick;
            total++; if (en16 !== 1'b1) $display("[TB] FAIL hit_enable c%0d: got %0h expected 1", c, en16); else passed++;
            total++; if (rdata16 !== 16'h1234) $display("[TB] FAIL hit_rdata c%0d: got %0h expected 1234", c, rdata16); else passed++;
            total++; if (mwe16 !== 1'b0) $display("[TB] FAIL hit_mem_we c%0d: got %0h expected 0", c, mwe16); else passed++;
        end
    endtask

    task automatic test_write_through;
        we16    = 1'b1;
        addr16  = 16'h0010;
        wdata16 = 16'hBEEF;
        #1;
        total++; if (en16 !== 1'b0) $display("[TB] FAIL wr_start_enable: got %0h expected 0", en16); else passed++;
        tick;
        total++; if (mwe16 !== 1'b1) $display("[TB] FAIL wr_b0_we: got %0h expected 1", mwe16); else passed++;
        total++; if (maddr16 !== 16'h0010) $display("[TB] FAIL wr_b0_addr: got %0h expected 10", maddr16); else passed++;
        total++; if (mwd16 !== 8'hEF) $display("[TB] FAIL wr_b0_data: got %0h expected ef", mwd16); else passed++;
        total++; if (en16 !== 1'b0) $display("[TB] FAIL wr_b0_enable: got %0h expected 0", en16); else passed++;
        tick;
        total++; if (mwe16 !== 1'b1) $display("[TB] FAIL wr_b1_we: got %0h expected 1", mwe16); else passed++;
        total++; if (maddr16 !== 16'h0011) $display("[TB] FAIL wr_b1_addr: got %0h expected 11", maddr16); else passed++;
        total++; if (mwd16 !== 8'hBE) $display("[TB] FAIL wr_b1_data: got %0h expected be", mwd16); else passed++;
        tick;
        total++; if (en16 !== 1'b1) $display("[TB] FAIL wdone_enable: got %0h expected 1", en16); else passed++;
        total++; if (mwe16 !== 1'b0) $display("[TB] FAIL wdone_mem_we: got %0h expected 0", mwe16); else passed++;
        total++; if (rdata16 !== 16'hBEEF) $display("[TB] FAIL wdone_rdata: got %0h expected beef", rdata16); else passed++;
        tick;
        total++; if (en16 !== 1'b0) $display("[TB] FAIL wdone_single_cycle: got %0h expected 0", en16); else passed++;
        we16 = 1'b0;
        #1;
        total++; if (en16 !== 1'b1) $display("[TB] FAIL wt_hit_enable: got %0h expected 1", en16); else passed++;
        total++; if (rdata16 !== 16'hBEEF) $display("[TB] FAIL wt_hit_rdata: got %0h expected beef", rdata16); else passed++;
        tick;
        total++; if (en16 !== 1'b1) $display("[TB] FAIL wt_no_refetch: got %0h expected 1", en16); else passed++;
        total++; if (mem16[16'h0010] !== 8'hEF) $display("[TB] FAIL wt_mem10: got %0h expected ef", mem16[16'h0010]); else passed++;
        total++; if (mem16[16'h0011] !== 8'hBE) $display("[TB] FAIL wt_mem11: got %0h expected be", mem16[16'h0011]); else passed++;
    endtask

    task automatic test_wrap;
        addr16 = 16'hFFFF;
        #1;
        for (int c = 0; c < 4; c++) begin
            total++; if (en16 !== 1'b0) $display("[TB] FAIL wrap_stall c%0d: got %0h expected 0", c, en16); else passed++;
            if (c == 1) begin
                total++; if (maddr16 !== 16'hFFFF) $display("[TB] FAIL wrap_addr0: got %0h expected ffff", maddr16); else passed++;
            end
            if (c == 2) begin
                total++; if (maddr16 !== 16'h0000) $display("[TB] FAIL wrap_addr1: got %0h expected 0", maddr16); else passed++;
            end
            tick;
        end
        total++; if (en16 !== 1'b1) $display("[TB] FAIL wrap_enable: got %0h expected 1", en16); else passed++;
        total++; if (rdata16 !== 16'h55AA) $display("[TB] FAIL wrap_rdata: got %0h expected 55aa", rdata16); else passed++;
    endtask

    task automatic test_reset_mid_read;
        addr16 = 16'h0010;
        #1;
        total++; if (en16 !== 1'b0) $display("[TB] FAIL rmr_miss: got %0h expected 0", en16); else passed++;
        tick;
        tick;
        reset16 = 1'b0;
        tick;
        addr16 = 16'hFFFF;
        #1;
        total++; if (en16 !== 1'b0) $display("[TB] FAIL rmr_valid_cleared: got %0h expected 0", en16); else passed++;
        total++; if (mwe16 !== 1'b0) $display("[TB] FAIL rmr_mem_we: got %0h expected 0", mwe16); else passed++;
        total++; if (rdata16 !== 16'h0000) $display("[TB] FAIL rmr_rdata: got %0h expected 0", rdata16); else passed++;
        reset16 = 1'b1;
        addr16  = 16'h0010;
        #1;
        for (int c = 0; c < 4; c++) begin
            total++; if (en16 !== 1'b0) $display("[TB] FAIL rmr_refetch_stall c%0d: got %0h expected 0", c, en16); else passed++;
            if (c == 1) begin
                total++; if (maddr16 !== 16'h0010) $display("[TB] FAIL rmr_refetch_addr: got %0h expected 10", maddr16); else passed++;
            end
            tick;
        end
        total++; if (en16 !== 1'b1) $display("[TB] FAIL rmr_refetch_enable: got %0h expected 1", en16); else passed++;
        total++; if (rdata16 !== 16'hBEEF) $display("[TB] FAIL rmr_refetch_rdata: got %0h expected beef", rdata16); else passed++;
    endtask

    task automatic test_word32;
        addr32  = 32'h0000_0100;
        reset32 = 1'b1;
        #1;
        for (int c = 0; c < 6; c++) begin
            total++; if (en32 !== 1'b0) $display("[TB] FAIL w32_stall c%0d: got %0h expected 0", c, en32); else passed++;
            if (c >= 1 && c <= 4) begin
                total++; if (maddr32 !== 32'h100 + c - 1) $display("[TB] FAIL w32_addr c%0d: got %0h expected %0h", c, maddr32, 32'h100 + c - 1); else passed++;
            end
            tick;
        end
        total++; if (en32 !== 1'b1) $display("[TB] FAIL w32_enable: got %0h expected 1", en32); else passed++;
        total++; if (rdata32 !== 32'h04030201) $display("[TB] FAIL w32_rdata: got %0h expected 4030201", rdata32); else passed++;
    endtask

    task automatic test_word8;
        addr8  = 8'h42;
        reset8 = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            total++; if (en8 !== 1'b0) $display("[TB] FAIL w8_stall c%0d: got %0h expected 0", c, en8); else passed++;
            if (c == 1) begin
                total++; if (maddr8 !== 8'h42) $display("[TB] FAIL w8_addr: got %0h expected 42", maddr8); else passed++;
            end
            tick;
        end
        total++; if (en8 !== 1'b1) $display("[TB] FAIL w8_enable: got %0h expected 1", en8); else passed++;
        total++; if (rdata8 !== 8'h99) $display("[TB] FAIL w8_rdata: got %0h expected 99", rdata8); else passed++;
        we8    = 1'b1;
        wdata8 = 8'h5A;
        #1;
        total++; if (en8 !== 1'b0) $display("[TB] FAIL w8_wr_start: got %0h expected 0", en8); else passed++;
        tick;
        total++; if (mwe8 !== 1'b1) $display("[TB] FAIL w8_wr_we: got %0h expected 1", mwe8); else passed++;
        total++; if (mwd8 !== 8'h5A) $display("[TB] FAIL w8_wr_data: got %0h expected 5a", mwd8); else passed++;
        tick;
        total++; if (en8 !== 1'b1) $display("[TB] FAIL w8_wdone_enable: got %0h expected 1", en8); else passed++;
        total++; if (mwe8 !== 1'b0) $display("[TB] FAIL w8_wdone_we: got %0h expected 0", mwe8); else passed++;
        total++; if (rdata8 !== 8'h5A) $display("[TB] FAIL w8_wdone_rdata: got %0h expected 5a", rdata8); else passed++;
        we8 = 1'b0;
        tick;
        total++; if (en8 !== 1'b1) $display("[TB] FAIL w8_hit_after_write: got %0h expected 1", en8); else passed++;
        total++; if (mem8[8'h42] !== 8'h5A) $display("[TB] FAIL w8_mem: got %0h expected 5a", mem8[8'h42]); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem16[i] = 8'h00;
        for (int i = 0; i < 4096; i++) mem32[i] = 8'h00;
        for (int i = 0; i < 256; i++) mem8[i] = 8'h00;
        mem16[16'h0010] = 8'h34;
        mem16[16'h0011] = 8'h12;
        mem16[16'hFFFF] = 8'hAA;
        mem16[16'h0000] = 8'h55;
        mem32[12'h100]  = 8'h01;
        mem32[12'h101]  = 8'h02;
        mem32[12'h102]  = 8'h03;
        mem32[12'h103]  = 8'h04;
        mem8[8'h42]     = 8'h99;

        reset16 = 1'b0; addr16 = '0; wdata16 = '0; we16 = 1'b0;
        reset32 = 1'b0; addr32 = '0; wdata32 = '0; we32 = 1'b0;
        reset8  = 1'b0; addr8  = '0; wdata8  = '0; we8  = 1'b0;

        test_reset;
        test_miss_read;
        test_hit;
        test_write_through;
        test_wrap;
        test_reset_mid_read;
        test_word32;
        test_word8;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
